// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM states, oversampling constants and parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StDone
    } rx_state_e;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 7;
    localparam int unsigned DATA_BITS  = 8;

    localparam logic [3:0] TickLast = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TickMid  = 4'(MID_SAMPLE);
    localparam logic [2:0] BitLast  = 3'(DATA_BITS - 1);

    // High when the received data plus parity bit disagree with the selected parity sense.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] byte_i,
                                             input logic par_i, input logic odd_i);
        return (^byte_i) ^ par_i ^ odd_i;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with selectable reset value.
module sync_2ff #(
    parameter bit ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: start detection, 16x bit-centre sampling, shift strobes,
// parity/stop checking and a one-cycle valid strobe with error flags.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Rx_EN,
    input  logic                 Rx_sample_ENABLE,
    input  logic                 RxD,
    input  logic [DATA_BITS-1:0] shiftData,
    output logic                 shiftEnable,
    output logic                 data,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_FERROR,
    output logic                 Rx_PERROR
);

    rx_state_e            state_q;
    logic [3:0]           tick_cnt_q;
    logic [2:0]           bit_cnt_q;
    logic                 par_bit_q;
    logic                 stop_bit_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 rx_ferror_q;
    logic                 rx_perror_q;

    sync_2ff #(
        .ResetVal (1'b1)
    ) u_sync_rxd (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (RxD),
        .q_o    (data)
    );

    // Combinational so the strobe lands in the same cycle as the tick the shift register sees.
    assign shiftEnable = Rx_EN && Rx_sample_ENABLE && (state_q == StData) &&
                         (tick_cnt_q == TickLast);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            par_bit_q   <= 1'b0;
            stop_bit_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_ferror_q <= 1'b0;
            rx_perror_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (!Rx_EN) begin
                state_q    <= StIdle;
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (Rx_sample_ENABLE && !data) begin
                            state_q    <= StStart;
                            tick_cnt_q <= '0;
                        end
                    end
                    StStart: begin
                        if (Rx_sample_ENABLE) begin
                            if (tick_cnt_q == TickMid) begin
                                tick_cnt_q <= '0;
                                bit_cnt_q  <= '0;
                                state_q    <= data ? StIdle : StData;
                            end else begin
                                tick_cnt_q <= tick_cnt_q + 4'd1;
                            end
                        end
                    end
                    StData: begin
                        if (Rx_sample_ENABLE) begin
                            // 4-bit counter wraps 15 -> 0 on its own at each bit centre.
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                            if (tick_cnt_q == TickLast) begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                if (bit_cnt_q == BitLast) begin
                                    state_q <= PARITY_EN ? StParity : StStop;
                                end
                            end
                        end
                    end
                    StParity: begin
                        if (Rx_sample_ENABLE) begin
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                            if (tick_cnt_q == TickLast) begin
                                par_bit_q <= data;
                                state_q   <= StStop;
                            end
                        end
                    end
                    StStop: begin
                        if (Rx_sample_ENABLE) begin
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                            if (tick_cnt_q == TickLast) begin
                                stop_bit_q <= data;
                                state_q    <= StDone;
                            end
                        end
                    end
                    StDone: begin
                        rx_data_q   <= shiftData;
                        rx_ferror_q <= ~stop_bit_q;
                        rx_perror_q <= PARITY_EN & parity_mismatch(shiftData, par_bit_q, PARITY_ODD);
                        rx_valid_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign Rx_DATA   = rx_data_q;
    assign Rx_VALID  = rx_valid_q;
    assign Rx_FERROR = rx_ferror_q;
    assign Rx_PERROR = rx_perror_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Self-checking bench for uart_rx_controller: directed frames plus randomized bytes/errors
// compared against a frame-level reference model.
module tb_uart_rx_controller;

    localparam int BitClks = 64;  // 16 ticks per bit, one tick every 4 clk

    logic       clk = 1'b0;
    logic       reset;
    logic       Rx_EN;
    logic       tick;
    logic       RxD;
    logic [7:0] shiftData;
    logic       shiftEnable;
    logic       data;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_FERROR;
    logic       Rx_PERROR;

    int         n_cmp = 0;
    int         n_err = 0;
    int         shift_cnt = 0;
    int         tdiv = 0;
    logic       valid_prev = 1'b0;
    logic [9:0] obs_q[$];
    logic [7:0] sr_q;
    logic       sr_rst;

    always #5 clk = ~clk;

    uart_rx_controller dut (
        .clk              (clk),
        .reset            (reset),
        .Rx_EN            (Rx_EN),
        .Rx_sample_ENABLE (tick),
        .RxD              (RxD),
        .shiftData        (shiftData),
        .shiftEnable      (shiftEnable),
        .data             (data),
        .Rx_DATA          (Rx_DATA),
        .Rx_VALID         (Rx_VALID),
        .Rx_FERROR        (Rx_FERROR),
        .Rx_PERROR        (Rx_PERROR)
    );

    // External right-shifting receive register as wired by the parent receiver.
    assign sr_rst = ~reset;
    always_ff @(posedge clk or posedge sr_rst) begin
        if (sr_rst) sr_q <= '0;
        else if (tick && shiftEnable) sr_q <= {data, sr_q[7:1]};
    end
    assign shiftData = sr_q;

    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick = (tdiv == 3);
            tdiv = (tdiv + 1) % 4;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (Rx_VALID) begin
            check_eq("valid_width", 32'(valid_prev), 32'd0);
            obs_q.push_back({Rx_DATA, Rx_FERROR, Rx_PERROR});
        end
        if (shiftEnable) begin
            check_eq("shift_on_tick", 32'(tick), 32'd1);
            shift_cnt++;
        end
        valid_prev = Rx_VALID;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Line image of a frame, index 0 first on the wire: start, 8 data LSB first, parity, stop.
    function automatic logic [10:0] build_frame(input logic [7:0] b, input logic bad_par,
                                                input logic stop);
        logic par;
        par = (($countones(b) % 2) != 0) ^ bad_par;
        return {stop, par, b, 1'b0};
    endfunction

    task automatic drive_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            RxD = bits[i];
            wait_clks(BitClks);
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b, input logic fe,
                               input logic pe);
        logic [9:0] o;
        if (obs_q.size() == 0) begin
            check_eq({tag, "_valid_seen"}, 32'd0, 32'd1);
        end else begin
            o = obs_q.pop_front();
            check_eq({tag, "_data"}, 32'(o[9:2]), 32'(b));
            check_eq({tag, "_ferr"}, 32'(o[1]), 32'(fe));
            check_eq({tag, "_perr"}, 32'(o[0]), 32'(pe));
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input logic bad_par,
                             input logic stop);
        logic [10:0] bits;
        logic        exp_pe;
        shift_cnt = 0;
        bits = build_frame(b, bad_par, stop);
        drive_bits(bits, 11);
        RxD = 1'b1;
        wait_clks(3 * BitClks);
        exp_pe = ($countones({b, bits[9]}) % 2) != 0;
        check_frame(tag, b, ~stop, exp_pe);
        check_eq({tag, "_shifts"}, 32'(shift_cnt), 32'd8);
        check_eq({tag, "_extra"}, 32'(obs_q.size()), 32'd0);
    endtask

    initial begin
        logic [10:0] bits;
        reset = 1'b0;
        Rx_EN = 1'b1;
        RxD   = 1'b1;
        wait_clks(3);
        check_eq("rst_data", 32'(Rx_DATA), 32'h00);
        check_eq("rst_valid", 32'(Rx_VALID), 32'd0);
        check_eq("rst_ferr", 32'(Rx_FERROR), 32'd0);
        check_eq("rst_perr", 32'(Rx_PERROR), 32'd0);
        check_eq("rst_sync", 32'(data), 32'd1);
        check_eq("rst_shift", 32'(shiftEnable), 32'd0);
        reset = 1'b1;
        wait_clks(20);

        run_frame("a5", 8'hA5, 1'b0, 1'b1);
        run_frame("par_err", 8'h3C, 1'b1, 1'b1);
        run_frame("frm_err", 8'hFF, 1'b0, 1'b0);

        // Async reset while the parity bit is on the line.
        bits = build_frame(8'hC3, 1'b0, 1'b1);
        drive_bits(bits, 9);
        RxD = bits[9];
        wait_clks(32);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_data", 32'(Rx_DATA), 32'h00);
        check_eq("mid_rst_valid", 32'(Rx_VALID), 32'd0);
        check_eq("mid_rst_ferr", 32'(Rx_FERROR), 32'd0);
        check_eq("mid_rst_perr", 32'(Rx_PERROR), 32'd0);
        check_eq("mid_rst_sync", 32'(data), 32'd1);
        check_eq("mid_rst_no_valid", 32'(obs_q.size()), 32'd0);
        RxD = 1'b1;
        wait_clks(5);
        reset = 1'b1;
        wait_clks(BitClks);
        run_frame("post_rst", 8'h81, 1'b0, 1'b1);

        // Start-bit glitch of 4 ticks.
        shift_cnt = 0;
        RxD = 1'b0;
        wait_clks(16);
        RxD = 1'b1;
        wait_clks(2 * BitClks);
        check_eq("glitch_shifts", 32'(shift_cnt), 32'd0);
        check_eq("glitch_valid", 32'(obs_q.size()), 32'd0);
        run_frame("after_glitch", 8'h42, 1'b0, 1'b1);

        // Abort after three data bits, then recover.
        bits = build_frame(8'h77, 1'b0, 1'b1);
        drive_bits(bits, 4);
        RxD = 1'b1;
        Rx_EN = 1'b0;
        wait_clks(10);
        check_eq("abort_hold_data", 32'(Rx_DATA), 32'h42);
        Rx_EN = 1'b1;
        wait_clks(BitClks);
        check_eq("abort_no_valid", 32'(obs_q.size()), 32'd0);
        run_frame("abort_rec", 8'h5A, 1'b0, 1'b1);

        // Back-to-back frames with no idle gap.
        shift_cnt = 0;
        drive_bits(build_frame(8'h01, 1'b0, 1'b1), 11);
        drive_bits(build_frame(8'h80, 1'b0, 1'b1), 11);
        RxD = 1'b1;
        wait_clks(3 * BitClks);
        check_frame("b2b_0", 8'h01, 1'b0, 1'b0);
        check_frame("b2b_1", 8'h80, 1'b0, 1'b0);
        check_eq("b2b_shifts", 32'(shift_cnt), 32'd16);
        check_eq("b2b_extra", 32'(obs_q.size()), 32'd0);

        for (int i = 0; i < 12; i++) begin
            wait_clks($urandom_range(0, 7));
            run_frame("rnd", 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 5) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_controller.md
# uart_rx_controller

Sequencing FSM for the UART receive path: detects the start bit on the serial line, steps through the 16x-oversampled bit periods, and drives the right-shifting 8-bit receive shift register's `shiftEnable`/`data` inputs at each bit centre. It samples and checks the parity and stop bits, then presents the assembled byte with a one-cycle valid strobe and error flags. It sits between the baud-rate sample-tick generator and the receiver's host-side interface.

## Interface
- `PARITY_EN`, default 1, meaning: 1 = a parity bit follows the data bits; 0 = no parity bit.
- `PARITY_ODD`, default 0, meaning: 0 = even parity, 1 = odd parity.
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-low reset.
- `Rx_EN`  input  1  receiver enable; low forces IDLE.
- `Rx_sample_ENABLE`  input  1  16x-oversampling tick, one `clk` wide.
- `RxD`  input  1  asynchronous serial line, idle high.
- `shiftData`  input  8  current contents of the receive shift register.
- `shiftEnable`  output  1  shift strobe to the shift register.
- `data`  output  1  synchronized serial bit fed to the shift register.
- `Rx_DATA`  output  8  received byte, registered.
- `Rx_VALID`  output  1  one-cycle strobe: `Rx_DATA` and the error flags are valid.
- `Rx_FERROR`  output  1  stop bit sampled low; qualified by `Rx_VALID`.
- `Rx_PERROR`  output  1  parity mismatch; qualified by `Rx_VALID`.

## Operation
- `RxD` passes through a 2-FF synchronizer; `data` is the second-stage output. All FSM decisions use `data`.
- All counters advance only on `clk` edges where `Rx_sample_ENABLE` is high.
  - `tick_cnt` is 4 bits.
  - `bit_cnt` is 3 bits.
- FSM states:
  - IDLE:
    - On a tick with `data`=0: go to START, with `tick_cnt`=0.
  - START:
    - Advance `tick_cnt` on each tick.
    - On the tick where `tick_cnt`=7 (mid start bit):
      - If `data`=1 (glitch): return to IDLE, with no strobe.
      - Otherwise: go to DATA with `tick_cnt`=0 and `bit_cnt`=0.
  - DATA:
    - On each tick where `tick_cnt`=15: assert `shiftEnable` for that cycle, clear `tick_cnt`, and increment `bit_cnt`.
    - After the 8th shift (`bit_cnt` was 7): go to PARITY if `PARITY_EN`, otherwise to STOP.
  - PARITY:
    - On the tick where `tick_cnt`=15: capture `data` into `par_bit`, then go to STOP.
  - STOP:
    - On the tick where `tick_cnt`=15: capture `data`.
    - Next `clk`: go to DONE.
  - DONE (one `clk`):
    - `Rx_DATA` <= `shiftData`.
    - `Rx_FERROR` <= (stop sample == 0).
    - `Rx_PERROR` <= `PARITY_EN` & ((^`shiftData`) ^ `par_bit` ^ `PARITY_ODD`).
    - Assert `Rx_VALID`, then return to IDLE.
- Data bits arrive LSB first. Because the shift register shifts right, bit 0 ends in `shiftData[0]`.
- `shiftEnable` is asserted only in DATA, and only in a cycle where `Rx_sample_ENABLE`=1. The shift register's own gating is therefore redundant but harmless.
- Frame errors still deliver the byte, with `Rx_FERROR`=1. There is no break detection; a low line after DONE is treated as a new start.
- `Rx_EN`=0 in any state:
  - Next `clk`: IDLE, with counters cleared.
  - No `Rx_VALID` for the aborted frame.
  - `Rx_DATA` holds its last value.

## Timing
- Reset values: `shiftEnable`=0, `data`=1 (synchronizer presets high), `Rx_DATA`=8'h00, `Rx_VALID`=0, `Rx_FERROR`=0, `Rx_PERROR`=0. FSM=IDLE, all counters 0.
- Reset asserted mid-frame aborts the frame immediately and asynchronously.
- Synchronizer latency: 2 `clk`.
- Start detection granularity: 1 tick.
- Bit sampling: bit centres are 16 ticks apart, with the first data sample 24 ticks after the start detection tick.
- `Rx_VALID` is asserted exactly 2 `clk` after the stop-bit sample tick (STOP→DONE, then the registered outputs) and lasts exactly 1 `clk`.
- `Rx_FERROR`/`Rx_PERROR` change only in DONE and hold until the next DONE.
- Simultaneous `Rx_EN` falling and a sample tick: the disable wins and the tick is ignored.

## Structure
- A shared `uart_pkg` holds:
  - the state encoding localparams (IDLE, START, DATA, PARITY, STOP, DONE);
  - `OVERSAMPLE`=16 and `MID_SAMPLE`=7;
  - `DATA_BITS`=8.
- One natural sub-module: `sync_2ff` (two-flop synchronizer with a preset-high option), reusable for other asynchronous inputs.
- The shift register stays a separate instance, wired by the parent receiver: `shiftEnable`→`shiftEnable`, `data`→`data`, `tempOut`→`shiftData`. The same `Rx_sample_ENABLE` and `clk` go to both the controller and the shift register. The controller's active-low `reset` must be inverted to drive the shift register's active-high `reset` input.

## Test plan
- Even parity, byte 0xA5.
  - Stimulus: frame 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1.
  - Required: `Rx_DATA`=8'hA5, one `Rx_VALID` pulse, FERROR=0, PERROR=0, exactly 8 `shiftEnable` pulses.
- Parity error, byte 0x3C.
  - Stimulus: byte 0x3C with the parity bit forced to 1 (even parity).
  - Required: `Rx_DATA`=8'h3C, `Rx_PERROR`=1, `Rx_FERROR`=0.
- Framing error, byte 0xFF.
  - Stimulus: byte 0xFF with the stop bit driven 0.
  - Required: `Rx_DATA`=8'hFF, `Rx_FERROR`=1, valid strobe still produced.
- Start-bit glitch.
  - Stimulus: `RxD` low for 4 ticks, then high.
  - Required: FSM back in IDLE, no `shiftEnable`, no `Rx_VALID`.
- Abort and recovery.
  - Stimulus: `Rx_EN` deasserted after 3 data bits, then reasserted, then a clean 0x5A frame.
  - Required: no strobe for the aborted frame, then `Rx_DATA`=8'h5A.
- Asynchronous reset mid-frame.
  - Stimulus: `reset` pulsed low mid-PARITY.
  - Required: all outputs at their reset values immediately; the next frame 0x81 is received correctly.
- Back-to-back frames.
  - Stimulus: frames 0x01 and 0x80 with no idle gap between them.
  - Required: two `Rx_VALID` pulses with the correct bytes.
